fifo_access_arbiter: RTL and testbench

- Front-end scheduler for the board FIFO.
- Shares the FIFO's single write port between two requesters (A, B) using round-robin arbitration.
- Services one read requester.
- Tracks occupancy so the FIFO never overflows or underflows, and drives registered single-cycle write/read enables plus write data straight into the FIFO.

---
 rtl/fifo_access_arbiter.sv | 170 +++++++++++++++++
 tb/tb_fifo_access_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_access_arbiter.sv
// fifo_access_arbiter
//   Front-end scheduler for the board FIFO. Two write requesters (A, B) share
//   the FIFO's single write port through round-robin arbitration, and one read
//   requester is serviced alongside. A local occupancy count keeps the FIFO
//   from overflowing or underflowing. Every grant and enable is registered and
//   lasts exactly one cycle.
//
//   Optional build macro: FIFO_ARB_ERR_FLAGS_EN adds the err_clr input and the
//   sticky err_ovf / err_udf outputs.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   flush               level-sensitive flush request
//   req_a/data_a/gnt_a  requester A: request, write data, grant pulse
//   req_b/data_b/gnt_b  requester B: request, write data, grant pulse
//   rd_req/rd_gnt       read request and read grant pulse
//   fifo_wr_en/_data    write strobe and write data driven into the FIFO
//   fifo_rd_en          read strobe driven into the FIFO
//   fifo_clr            one-cycle FIFO clear pulse
//   level/full/empty    registered occupancy and its two flags
//   err_clr/err_ovf/err_udf  (macro only) sticky blocked-request flags
module fifo_access_arbiter #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int CNT_W       = 5,
  parameter int INIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  req_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  output logic                  gnt_a,
  input  logic                  req_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic                  gnt_b,
  input  logic                  rd_req,
  output logic                  rd_gnt,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_wr_data,
  output logic                  fifo_rd_en,
  output logic                  fifo_clr,
  output logic [CNT_W-1:0]      level,
  output logic                  full,
  output logic                  empty
`ifdef FIFO_ARB_ERR_FLAGS_EN
  ,
  input  logic                  err_clr,
  output logic                  err_ovf,
  output logic                  err_udf
`endif
);

  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  // INIT always lasts at least one edge, even when INIT_CYCLES is 0.
  localparam int          ICW       = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES + 1) : 1;
  localparam logic [ICW-1:0] INIT_LAST = (INIT_CYCLES > 0) ? ICW'(INIT_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [1:0]       state;
  logic [ICW-1:0]   init_cnt;
  logic             ptr_b;      // 1: B has priority on the next tie

  logic             run_ok;
  logic             a_req, b_req, r_req;
  logic             rd_win, wr_room;
  logic             a_ok, b_ok, a_win, b_win, wr_win;
  logic [CNT_W-1:0] level_nxt;

  // A request is masked while its own grant is high. That registered grant
  // refers to the request the holder is only now dropping, so it must not be
  // counted a second time.
  assign a_req  = req_a  & ~gnt_a;
  assign b_req  = req_b  & ~gnt_b;
  assign r_req  = rd_req & ~rd_gnt;

  // Flush takes priority over every request in the cycle it is seen.
  assign run_ok = (state == S_RUN) & ~flush;

  // The read decision depends only on current occupancy. A write cannot make
  // an empty FIFO readable in the same cycle. A full FIFO can accept a write
  // when a read drains one word at the same edge.
  assign rd_win  = run_ok & r_req & ~empty;
  assign wr_room = ~full | rd_win;
  assign a_ok    = run_ok & a_req & wr_room;
  assign b_ok    = run_ok & b_req & wr_room;
  assign a_win   = a_ok & (~b_ok | ~ptr_b);
  assign b_win   = b_ok & (~a_ok |  ptr_b);
  assign wr_win  = a_win | b_win;

  always_comb begin
    level_nxt = level;
    if ((state == S_RUN) && flush) begin
      level_nxt = '0;
    end else if (wr_win && !rd_win) begin
      level_nxt = level + CNT_W'(1);
    end else if (rd_win && !wr_win) begin
      level_nxt = level - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_INIT;
      init_cnt     <= '0;
      ptr_b        <= 1'b0;
      gnt_a        <= 1'b0;
      gnt_b        <= 1'b0;
      rd_gnt       <= 1'b0;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
      fifo_rd_en   <= 1'b0;
      fifo_clr     <= 1'b0;
      level        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
    end else begin
      case (state)
        S_INIT: begin
          if (init_cnt == INIT_LAST) state <= S_RUN;
          else                       init_cnt <= init_cnt + ICW'(1);
        end
        S_RUN:   if (flush) state <= S_FLUSH;
        S_FLUSH: state <= S_RUN;
        default: state <= S_INIT;
      endcase

      gnt_a      <= a_win;
      gnt_b      <= b_win;
      rd_gnt     <= rd_win;
      fifo_wr_en <= wr_win;
      fifo_rd_en <= rd_win;
      fifo_clr   <= (state == S_RUN) & flush;
      level      <= level_nxt;
      full       <= (level_nxt == DEPTH_C);
      empty      <= (level_nxt == '0);

      // Write data is only loaded on a write, so it holds the last value
      // that was written.
      if (wr_win) begin
        fifo_wr_data <= a_win ? data_a : data_b;
        ptr_b        <= a_win;
      end
    end
  end

`ifdef FIFO_ARB_ERR_FLAGS_EN
  logic ovf_set, udf_set;

  // A flag sets only when the named flag is the sole reason for the block.
  // It does not set when the request is masked by its own grant or when the
  // block comes from INIT or FLUSH.
  assign ovf_set = run_ok & (a_req | b_req) & full & ~rd_win;
  assign udf_set = run_ok & r_req & empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      err_ovf <= ovf_set | (err_ovf & ~err_clr);
      err_udf <= udf_set | (err_udf & ~err_clr);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_access_arbiter.sv
module tb_fifo_access_arbiter;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int CW = 5;
  localparam int IC = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          req_a = 1'b0, req_b = 1'b0, rd_req = 1'b0;
  logic [DW-1:0] data_a = '0, data_b = '0;
  logic          gnt_a, gnt_b, rd_gnt, fifo_wr_en, fifo_rd_en, fifo_clr, full, empty;
  logic [DW-1:0] fifo_wr_data;
  logic [CW-1:0] level;
`ifdef FIFO_ARB_ERR_FLAGS_EN
  logic          err_clr = 1'b0;
  logic          err_ovf, err_udf;
`endif

  fifo_access_arbiter #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_W(CW), .INIT_CYCLES(IC)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_a(req_a), .data_a(data_a), .gnt_a(gnt_a),
    .req_b(req_b), .data_b(data_b), .gnt_b(gnt_b),
    .rd_req(rd_req), .rd_gnt(rd_gnt),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .fifo_rd_en(fifo_rd_en), .fifo_clr(fifo_clr),
    .level(level), .full(full), .empty(empty)
`ifdef FIFO_ARB_ERR_FLAGS_EN
    , .err_clr(err_clr), .err_ovf(err_ovf), .err_udf(err_udf)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural reference: phase tracked as a countdown and a flush flag,
  // occupancy as a plain integer, fairness as "who was granted last".
  int          m_init, m_lvl;
  bit          m_in_flush, m_last_a;
  bit          m_ga, m_gb, m_rg, m_clr;
  logic [DW-1:0] m_wd;
  bit          m_eo, m_eu;

  logic [DW+CW+7:0] dv;
  assign dv = {gnt_a, gnt_b, rd_gnt, fifo_wr_en, fifo_rd_en, fifo_clr, full, empty,
               fifo_wr_data, level};

  function automatic logic [DW+CW+7:0] exp_vec();
    logic [CW-1:0] l;
    l = CW'(m_lvl);
    return {m_ga, m_gb, m_rg, m_ga | m_gb, m_rg, m_clr, m_lvl == DEPTH, m_lvl == 0, m_wd, l};
  endfunction

  task automatic model_reset();
    m_init = IC; m_lvl = 0; m_in_flush = 0; m_last_a = 0;
    m_ga = 0; m_gb = 0; m_rg = 0; m_clr = 0; m_wd = '0; m_eo = 0; m_eu = 0;
  endtask

  // Advance the model from the inputs as they stand before the edge, then
  // step the clock and settle just after the edge.
  task automatic tick();
    bit a, b, r, rd, room, ga, gb, ovf, udf;
    ga = 0; gb = 0; rd = 0; ovf = 0; udf = 0;
    if (!rst) begin
      model_reset();
    end else begin
      a = req_a && !m_ga;
      b = req_b && !m_gb;
      r = rd_req && !m_rg;
      m_clr = 0;
      if (m_init > 0) m_init--;
      else if (m_in_flush) m_in_flush = 0;
      else if (flush) begin m_in_flush = 1; m_clr = 1; m_lvl = 0; end
      else begin
        rd   = r && (m_lvl > 0);
        room = (m_lvl < DEPTH) || rd;
        if (room && a && b) begin
          if (m_last_a) gb = 1; else ga = 1;
        end else if (room) begin
          ga = a; gb = b;
        end
        ovf = (a || b) && (m_lvl == DEPTH) && !rd;
        udf = r && (m_lvl == 0);
        if (ga || gb) begin
          m_wd = ga ? data_a : data_b;
          m_last_a = ga;
        end
        m_lvl = m_lvl + int'(ga || gb) - int'(rd);
      end
`ifdef FIFO_ARB_ERR_FLAGS_EN
      m_eo = ovf || (m_eo && !err_clr);
      m_eu = udf || (m_eu && !err_clr);
`endif
      m_ga = ga; m_gb = gb; m_rg = rd;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    req_a = 0; req_b = 0; rd_req = 0; flush = 0;
`ifdef FIFO_ARB_ERR_FLAGS_EN
    err_clr = 0;
`endif
    rst = 0; #1;
    model_reset();
    tick();
    rst = 1;
    tick(); tick();
  endtask

  task automatic test_reset();
    #2 rst = 0; #1;
    model_reset();
    checks++;
    if (dv !== exp_vec() || empty !== 1'b1 || level !== '0) begin
      errors++; $display("FAIL reset_state: got %h want %h", dv, exp_vec());
    end
    req_a = 1; data_a = 8'h07;
    tick(); tick();
    rst = 1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      checks++;
      if (gnt_a !== (e == 3) || fifo_wr_en !== (e == 3)) begin
        errors++; $display("FAIL reset_first_grant edge %0d: gnt_a=%b wr_en=%b want %b", e, gnt_a, fifo_wr_en, e == 3);
      end
    end
    checks++;
    if (fifo_wr_data !== 8'h07 || level !== 5'd1 || empty !== 1'b0) begin
      errors++; $display("FAIL reset_first_write: data=%h level=%0d empty=%b want 07/1/0", fifo_wr_data, level, empty);
    end
    req_a = 0;
    tick();
  endtask

  task automatic test_contention();
    int writes = 0;
    do_reset();
    req_a = 1; req_b = 1; data_a = 8'hAA; data_b = 8'h55;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (dv !== exp_vec()) begin
        errors++; $display("FAIL contention_model cyc %0d: got %h want %h", i, dv, exp_vec());
      end
      checks++;
      if (gnt_a !== (i % 2 == 0) || gnt_b !== (i % 2 == 1)) begin
        errors++; $display("FAIL contention_order cyc %0d: gnt_a=%b gnt_b=%b", i, gnt_a, gnt_b);
      end
      if (fifo_wr_en) writes++;
    end
    req_a = 0; req_b = 0;
    checks++;
    if (writes != 8 || level !== 5'd8) begin
      errors++; $display("FAIL contention_count: writes=%0d level=%0d want 8/8", writes, level);
    end
  endtask

  task automatic test_fill_full();
    int wr = 0, rdn = 0;
    do_reset();
    req_a = 1; data_a = 8'($urandom);
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if (dv !== exp_vec()) begin
        errors++; $display("FAIL fill_model cyc %0d: got %h want %h", i, dv, exp_vec());
      end
      if (gnt_a) data_a = 8'($urandom);
    end
    checks++;
    if (level !== 5'd16 || full !== 1'b1) begin
      errors++; $display("FAIL fill_full: level=%0d full=%b want 16/1", level, full);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (fifo_wr_en) wr++;
    end
    checks++;
    if (wr != 0) begin
      errors++; $display("FAIL fill_no_write_when_full: writes=%0d want 0", wr);
    end
    rd_req = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (dv !== exp_vec() || level !== 5'd16) begin
        errors++; $display("FAIL full_rw cyc %0d: got %h want %h", i, dv, exp_vec());
      end
      if (fifo_wr_en) wr++;
      if (fifo_rd_en) rdn++;
      if (gnt_a) data_a = 8'($urandom);
    end
    checks++;
    if (wr != 4 || rdn != 4) begin
      errors++; $display("FAIL full_rw_count: writes=%0d reads=%0d want 4/4", wr, rdn);
    end
    rd_req = 0; req_a = 0;
  endtask

  task automatic test_empty_read();
    do_reset();
    rd_req = 1; req_b = 1; data_b = 8'h3C;
    tick();
    checks++;
    if (gnt_b !== 1'b1 || rd_gnt !== 1'b0 || level !== 5'd1 || fifo_wr_data !== 8'h3C) begin
      errors++; $display("FAIL empty_read_first: gnt_b=%b rd_gnt=%b level=%0d want 1/0/1", gnt_b, rd_gnt, level);
    end
    req_b = 0;
    tick();
    checks++;
    if (rd_gnt !== 1'b1 || fifo_rd_en !== 1'b1 || level !== 5'd0 || empty !== 1'b1) begin
      errors++; $display("FAIL empty_read_second: rd_gnt=%b level=%0d empty=%b want 1/0/1", rd_gnt, level, empty);
    end
    rd_req = 0;
    tick();
  endtask

  task automatic test_flush();
    int guard = 0;
    do_reset();
    req_a = 1; req_b = 1; data_a = 8'h11; data_b = 8'h22;
    while (m_lvl < 5 && guard < 20) begin tick(); guard++; end
    checks++;
    if (level !== 5'd5) begin
      errors++; $display("FAIL flush_setup: level=%0d want 5", level);
    end
    req_b = 0; flush = 1;
    tick();
    flush = 0;
    checks++;
    if (fifo_clr !== 1'b1 || level !== 5'd0 || gnt_a !== 1'b0 || gnt_b !== 1'b0 || empty !== 1'b1) begin
      errors++; $display("FAIL flush_pulse: clr=%b level=%0d gnt=%b%b want 1/0/00", fifo_clr, level, gnt_a, gnt_b);
    end
    tick();
    checks++;
    if (fifo_clr !== 1'b0 || gnt_a !== 1'b0) begin
      errors++; $display("FAIL flush_recover: clr=%b gnt_a=%b want 0/0", fifo_clr, gnt_a);
    end
    tick();
    checks++;
    if (gnt_a !== 1'b1 || level !== 5'd1 || fifo_wr_data !== 8'h11) begin
      errors++; $display("FAIL flush_then_serve: gnt_a=%b level=%0d data=%h want 1/1/11", gnt_a, level, fifo_wr_data);
    end
    req_a = 0;
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      tick();
      checks++;
      if (dv !== exp_vec()) begin
        errors++; $display("FAIL random_model cyc %0d: got %h want %h", i, dv, exp_vec());
      end
`ifdef FIFO_ARB_ERR_FLAGS_EN
      checks++;
      if (err_ovf !== m_eo || err_udf !== m_eu) begin
        errors++; $display("FAIL random_err cyc %0d: ovf=%b udf=%b want %b %b", i, err_ovf, err_udf, m_eo, m_eu);
      end
      err_clr = ($urandom % 8) == 0;
`endif
      if (!req_a || gnt_a) begin req_a = ($urandom % 3) != 0; data_a = 8'($urandom); end
      if (!req_b || gnt_b) begin req_b = ($urandom % 2) != 0; data_b = 8'($urandom); end
      if (!rd_req || rd_gnt) rd_req = ($urandom % 3) == 0;
      flush = ($urandom % 50) == 0;
    end
    req_a = 0; req_b = 0; rd_req = 0; flush = 0;
  endtask

`ifdef FIFO_ARB_ERR_FLAGS_EN
  task automatic test_err_flags();
    do_reset();
    req_a = 1; req_b = 1;
    for (int i = 0; i < 16; i++) tick();
    req_a = 0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (full !== 1'b1 || err_ovf !== 1'b1 || err_ovf !== m_eo) begin
      errors++; $display("FAIL err_ovf_set: full=%b ovf=%b want 1/1", full, err_ovf);
    end
    req_b = 0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (err_ovf !== 1'b1) begin
      errors++; $display("FAIL err_ovf_sticky: ovf=%b want 1", err_ovf);
    end
    err_clr = 1;
    tick();
    err_clr = 0;
    checks++;
    if (err_ovf !== 1'b0) begin
      errors++; $display("FAIL err_ovf_clear: ovf=%b want 0", err_ovf);
    end
    do_reset();
    rd_req = 1;
    tick();
    checks++;
    if (err_udf !== 1'b1 || rd_gnt !== 1'b0) begin
      errors++; $display("FAIL err_udf_set: udf=%b rd_gnt=%b want 1/0", err_udf, rd_gnt);
    end
    rd_req = 0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_contention();
    test_fill_full();
    test_empty_read();
    test_flush();
`ifdef FIFO_ARB_ERR_FLAGS_EN
    test_err_flags();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
